// File: rtl/bean_map.sv
// Bean field owner: ten alive bits, a sequential eat scanner and a registered
// per-pixel bean lookup for the renderer.
module bean_map #(
    parameter int NUM_BEANS = 10,
    parameter int BLOCK_PX  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       eat_valid,
    output logic       eat_ready,
    input  logic [5:0] eat_x,
    input  logic [4:0] eat_y,
    output logic       eaten_pulse,
    output logic [3:0] beans_left,
    output logic       all_eaten,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       bean_on
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    function automatic logic [5:0] romX(input int k);
        case (k)
            0, 2:    return 6'd2;
            1, 3:    return 6'd39;
            4, 6:    return 6'd10;
            5, 7:    return 6'd31;
            8:       return 6'd13;
            9:       return 6'd28;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [4:0] romY(input int k);
        case (k)
            0, 1:    return 5'd2;
            2, 3:    return 5'd27;
            4, 5:    return 5'd6;
            6, 7:    return 5'd24;
            8, 9:    return 5'd11;
            default: return 5'd0;
        endcase
    endfunction

    logic [0:0]           r_state;
    logic [3:0]           r_idx;
    logic [5:0]           r_x;
    logic [4:0]           r_y;
    logic [NUM_BEANS-1:0] r_alive;
    logic [3:0]           r_beansLeft;
    logic                 r_pulse;
    logic                 r_beanOn;
    logic [NUM_BEANS-1:0] w_hit;
    logic                 w_match;
    logic                 w_last;

    assign eat_ready   = (r_state == ST_IDLE) && !restart;
    assign eaten_pulse = r_pulse;
    assign beans_left  = r_beansLeft;
    assign all_eaten   = (r_beansLeft == 4'd0);
    assign bean_on     = r_beanOn;

    assign w_match = r_alive[r_idx] && (romX(int'(r_idx)) == r_x) && (romY(int'(r_idx)) == r_y);
    assign w_last  = (r_idx == 4'(NUM_BEANS - 1));

    // Rectangle bounds fold to constants per bean, so the lookup is pure compares.
    for (genvar k = 0; k < NUM_BEANS; k++) begin : g_bean
        localparam logic [9:0] X_LO = 10'(BLOCK_PX * int'(romX(k)) - BLOCK_PX);
        localparam logic [9:0] X_HI = 10'(BLOCK_PX * int'(romX(k)) - 1);
        localparam logic [9:0] Y_LO = 10'(BLOCK_PX * int'(romY(k)) - BLOCK_PX);
        localparam logic [9:0] Y_HI = 10'(BLOCK_PX * int'(romY(k)) - 1);
        assign w_hit[k] = r_alive[k] && (pix_x >= X_LO) && (pix_x <= X_HI)
                                     && (pix_y >= Y_LO) && (pix_y <= Y_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 4'd0;
            r_x         <= 6'd0;
            r_y         <= 5'd0;
            r_alive     <= '1;
            r_beansLeft <= 4'(NUM_BEANS);
            r_pulse     <= 1'b0;
        end else if (restart) begin
            r_state     <= ST_IDLE;
            r_idx       <= 4'd0;
            r_alive     <= '1;
            r_beansLeft <= 4'(NUM_BEANS);
            r_pulse     <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (eat_valid) begin
                        r_x     <= eat_x;
                        r_y     <= eat_y;
                        r_idx   <= 4'd0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_match) begin
                        r_alive[r_idx] <= 1'b0;
                        r_pulse        <= 1'b1;
                        r_beansLeft    <= (r_beansLeft == 4'd0) ? 4'd0 : r_beansLeft - 4'd1;
                        r_state        <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beanOn <= 1'b0;
        end else begin
            r_beanOn <= |w_hit;
        end
    end

endmodule

// File: tb/tb_bean_map.sv
// Randomized and directed bench for bean_map, checked every cycle against a
// transaction-level model of the bean field.
module tb_bean_map;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       eat_valid = 1'b0;
    logic       eat_ready;
    logic [5:0] eat_x = '0;
    logic [4:0] eat_y = '0;
    logic       eaten_pulse;
    logic [3:0] beans_left;
    logic       all_eaten;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       bean_on;

    bean_map #(.NUM_BEANS(10), .BLOCK_PX(10)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .eat_valid(eat_valid), .eat_ready(eat_ready), .eat_x(eat_x), .eat_y(eat_y),
        .eaten_pulse(eaten_pulse), .beans_left(beans_left), .all_eaten(all_eaten),
        .pix_x(pix_x), .pix_y(pix_y), .bean_on(bean_on)
    );

    always #5 clk = ~clk;

    int romBx[10] = '{2, 39, 2, 39, 10, 31, 10, 31, 13, 28};
    int romBy[10] = '{2, 2, 27, 27, 6, 6, 24, 24, 11, 11};

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 1'b0;
    bit pixRand = 1'b0;

    // Model: which beans live, how many remain, and how many busy cycles the
    // current request still owes before the block is ready again.
    bit [9:0] mAlive;
    int       mLeft;
    int       mBusy;
    int       mTarget;
    bit       mPulse;
    bit       mOn;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: timed out waiting, got no response, expected one", name);
    endtask

    task automatic modelReset();
        mAlive  = '1;
        mLeft   = 10;
        mBusy   = 0;
        mTarget = -1;
        mPulse  = 1'b0;
        mOn     = 1'b0;
    endtask

    function automatic bit inRect(input int k, input int px, input int py);
        return (px >= 10 * romBx[k] - 10) && (px <= 10 * romBx[k] - 1)
            && (py >= 10 * romBy[k] - 10) && (py <= 10 * romBy[k] - 1);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            modelReset();
        end else begin : step
            bit on;
            on = 1'b0;
            for (int k = 0; k < 10; k++)
                if (mAlive[k] && inRect(k, int'(pix_x), int'(pix_y))) on = 1'b1;
            mOn = on;
            if (restart) begin
                mAlive  = '1;
                mLeft   = 10;
                mBusy   = 0;
                mTarget = -1;
                mPulse  = 1'b0;
            end else begin
                mPulse = 1'b0;
                if (mBusy > 0) begin
                    mBusy--;
                    if (mBusy == 0 && mTarget >= 0) begin
                        mAlive[mTarget] = 1'b0;
                        if (mLeft > 0) mLeft--;
                        mPulse = 1'b1;
                    end
                end else if (eat_valid) begin
                    mTarget = -1;
                    for (int k = 0; k < 10; k++)
                        if (mTarget < 0 && mAlive[k] && romBx[k] == int'(eat_x) && romBy[k] == int'(eat_y))
                            mTarget = k;
                    mBusy = (mTarget >= 0) ? mTarget + 1 : 10;
                end
            end
        end
        #1;
        if (checkOn) begin
            checkOutput("eat_ready", eat_ready, (mBusy == 0 && !restart));
            checkOutput("eaten_pulse", eaten_pulse, mPulse);
            checkOutput("beans_left", beans_left, mLeft);
            checkOutput("all_eaten", all_eaten, (mLeft == 0));
            checkOutput("bean_on", bean_on, mOn);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (pixRand) begin
                if ($urandom % 2 == 0) begin
                    int k;
                    k = int'($urandom % 10);
                    pix_x = 10'(10 * romBx[k] - 12 + int'($urandom % 14));
                    pix_y = 10'(10 * romBy[k] - 12 + int'($urandom % 14));
                end else begin
                    pix_x = 10'($urandom % 640);
                    pix_y = 10'($urandom % 480);
                end
            end
        end
    end

    task automatic queryPix(input int px, input int py, input logic expected, input string name);
        @(negedge clk);
        pix_x = 10'(px);
        pix_y = 10'(py);
        @(posedge clk);
        #2;
        checkOutput(name, bean_on, expected);
    endtask

    // Issues one request; reports cycles eat_ready stayed low and the cycle the pulse showed.
    task automatic eatReq(input int x, input int y, input bit hold, output int lowCnt, output int pulseAt);
        int waitN;
        waitN = 0;
        lowCnt = -1;
        pulseAt = -1;
        @(negedge clk);
        while (!eat_ready && waitN < 40) begin
            waitN++;
            @(negedge clk);
        end
        if (!eat_ready) begin
            timeoutFail("eat_ready_wait");
            return;
        end
        eat_x = 6'(x);
        eat_y = 5'(y);
        eat_valid = 1'b1;
        @(posedge clk);
        #2;
        if (!hold) eat_valid = 1'b0;
        lowCnt = 0;
        pulseAt = 0;
        while (!eat_ready && lowCnt < 30) begin
            lowCnt++;
            @(posedge clk);
            #2;
            if (eaten_pulse) pulseAt = lowCnt;
        end
        if (!eat_ready) timeoutFail("eat_ready_return");
    endtask

    task automatic applyStimulus(input int cycles);
        pixRand = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            restart   = ($urandom % 50 == 0);
            eat_valid = ($urandom % 3 == 0);
            if ($urandom % 4 != 0) begin
                int k;
                k = int'($urandom % 10);
                eat_x = 6'(romBx[k]);
                eat_y = 5'(romBy[k]);
            end else begin
                eat_x = 6'($urandom % 64);
                eat_y = 5'($urandom % 32);
            end
        end
        @(negedge clk);
        restart   = 1'b0;
        eat_valid = 1'b0;
        pixRand   = 1'b0;
    endtask

    initial begin
        int lowCnt, pulseAt, pulses;
        checkOn = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_beans_left", beans_left, 10);
        checkOutput("reset_eat_ready", eat_ready, 1);
        checkOutput("reset_bean_on", bean_on, 0);
        @(negedge clk);
        reset = 1'b0;

        queryPix(10, 10, 1'b1, "pix_10_10");
        queryPix(9, 10, 1'b0, "pix_9_10");
        queryPix(19, 19, 1'b1, "pix_19_19");
        queryPix(20, 19, 1'b0, "pix_20_19");

        eatReq(2, 2, 1'b0, lowCnt, pulseAt);
        checkOutput("eat22_ready_low", lowCnt, 1);
        checkOutput("eat22_pulse_cycle", pulseAt, 1);
        checkOutput("eat22_beans_left", beans_left, 9);
        queryPix(15, 15, 1'b0, "pix_15_15_eaten");

        eatReq(28, 11, 1'b0, lowCnt, pulseAt);
        checkOutput("eat2811_ready_low", lowCnt, 10);
        checkOutput("eat2811_pulse_cycle", pulseAt, 10);
        checkOutput("eat2811_beans_left", beans_left, 8);
        eatReq(28, 11, 1'b0, lowCnt, pulseAt);
        checkOutput("eat2811_again_ready_low", lowCnt, 10);
        checkOutput("eat2811_again_no_pulse", pulseAt, 0);
        checkOutput("eat2811_again_beans_left", beans_left, 8);

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkOutput("restart_beans_left", beans_left, 10);

        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            eatReq(romBx[k], romBy[k], 1'b1, lowCnt, pulseAt);
            if (pulseAt > 0) pulses++;
        end
        checkOutput("held_pulse_count", pulses, 10);
        checkOutput("held_beans_left", beans_left, 0);
        checkOutput("held_all_eaten", all_eaten, 1);
        eatReq(2, 2, 1'b1, lowCnt, pulseAt);
        eat_valid = 1'b0;
        checkOutput("extra_no_pulse", pulseAt, 0);
        checkOutput("extra_beans_left", beans_left, 0);

        // Restart lands in the third scan cycle of a (dead) request.
        @(negedge clk);
        eat_x = 6'd39;
        eat_y = 5'd2;
        eat_valid = 1'b1;
        @(posedge clk);
        #2;
        eat_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        restart = 1'b1;
        eat_valid = 1'b1;
        eat_x = 6'd2;
        eat_y = 5'd2;
        @(posedge clk);
        #2;
        checkOutput("restart_ready_forced_low", eat_ready, 0);
        checkOutput("restart_pulse", eaten_pulse, 0);
        checkOutput("restart_mid_beans_left", beans_left, 10);
        @(negedge clk);
        restart = 1'b0;
        eat_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("restart_idle_ready", eat_ready, 1);
        checkOutput("restart_after_beans_left", beans_left, 10);
        queryPix(15, 15, 1'b1, "pix_15_15_rearmed");

        // Asynchronous reset in the middle of a scan.
        eatReq(2, 2, 1'b0, lowCnt, pulseAt);
        @(negedge clk);
        pix_x = 10'd385;
        pix_y = 10'd15;
        eat_x = 6'd28;
        eat_y = 5'd11;
        eat_valid = 1'b1;
        @(posedge clk);
        #2;
        eat_valid = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("pre_reset_bean_on", bean_on, 1);
        checkOutput("pre_reset_ready", eat_ready, 0);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset_ready", eat_ready, 1);
        checkOutput("async_reset_pulse", eaten_pulse, 0);
        checkOutput("async_reset_beans_left", beans_left, 10);
        checkOutput("async_reset_all_eaten", all_eaten, 0);
        checkOutput("async_reset_bean_on", bean_on, 0);
        #1;
        reset = 1'b0;

        applyStimulus(600);
        repeat (12) @(posedge clk);
        #3;
        checkOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bean_map.md
# bean_map

Sequential owner of the bean field for the maze. It holds one alive bit per bean at ten fixed block positions. It accepts eat requests carrying the pacman block position, clears a matching live bean and counts what remains. It also answers per-pixel "is a bean here" queries for the VGA renderer. It sits between the pacman movement logic, which issues block positions, and the pixel mux, which consumes `bean_on`.

## Interface
Parameters:
- `NUM_BEANS`, default 10: number of bean slots. The ROM below defines exactly 10 entries, so only 10 is legal.
- `BLOCK_PX`, default 10: pixel size of one maze block.

Ports:
- `clk`, in, 1: system clock. Everything below runs in this single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `restart`, in, 1: synchronous level. Re-arms all beans.
- `eat_valid`, in, 1: eat request valid.
- `eat_ready`, out, 1: block can accept an eat request.
- `eat_x`, in, 6: pacman block x. Legal range 1..40.
- `eat_y`, in, 5: pacman block y. Legal range 1..28.
- `eaten_pulse`, out, 1: one-cycle strobe when a bean is cleared.
- `beans_left`, out, 4: count of alive beans.
- `all_eaten`, out, 1: high when `beans_left` == 0.
- `pix_x`, in, 10: renderer pixel x.
- `pix_y`, in, 10: renderer pixel y.
- `bean_on`, out, 1: registered query result for the previous cycle's `pix_x`/`pix_y`.

## Operation
- Bean ROM entries (bx, by), indices 0..9: (2,2), (39,2), (2,27), (39,27), (10,6), (31,6), (10,24), (31,24), (13,11), (28,11). All positions are unique.
- Pixel rectangle of bean k:
  - x in [BLOCK_PX·bx − BLOCK_PX, BLOCK_PX·bx − 1]
  - y in [BLOCK_PX·by − BLOCK_PX, BLOCK_PX·by − 1]
  - Bounds are elaboration-time constants, 10 bits wide. No runtime multiply.
- `alive[9:0]` register:
  - All ones after `reset` and after `restart`.
  - A bit is cleared only by a SCAN match.
- FSM states: IDLE, SCAN.
  - IDLE: `eat_ready` = 1 (forced to 0 while `restart` = 1). When `eat_valid && eat_ready`, latch `eat_x`/`eat_y`, set `idx` = 0, go to SCAN.
  - SCAN: `eat_ready` = 0. Each cycle compare ROM[idx] with the latched position.
    - If `alive[idx]` and the position matches: clear `alive[idx]`, assert `eaten_pulse` next cycle, decrement `beans_left`, go to IDLE.
    - Else if `idx` == NUM_BEANS−1: go to IDLE with no pulse.
    - Else `idx` += 1.
- `restart` has highest priority:
  - Aborts a SCAN in progress: return to IDLE, `alive` = all ones, `beans_left` = 10.
  - Suppresses `eaten_pulse` and rejects a same-cycle request.
- Dead bean or out-of-range coordinates (0, x > 40, y > 28): full scan with no match and no state change.
- `beans_left` saturates at 0 and never wraps. `all_eaten` = (`beans_left` == 0).
- Pixel query:
  - `bean_on` = OR over k of (`alive[k]` && `pix` inside rect k).
  - All 10 comparisons evaluate in parallel, and the result is registered.
  - Independent of the FSM. A bean cleared in cycle N is not shown for queries sampled from cycle N+1 onward.

## Timing
- Reset values: state = IDLE, `eat_ready` = 1, `eaten_pulse` = 0, `beans_left` = 10, `all_eaten` = 0, `bean_on` = 0, `alive` = 10'h3FF, `idx` = 0.
- Eat latency:
  - Accept edge to match edge: idx+1 cycles.
  - `eaten_pulse` is high for exactly the one cycle after the clearing edge.
  - `eat_ready` returns to 1 in that same cycle.
  - A no-match request holds `eat_ready` low for 10 cycles.
- Eat throughput: one request per at most 11 cycles. `eat_valid` may be held high; a held request is re-accepted whenever `eat_ready` = 1, and the re-accept is harmless because the bean is already dead.
- `bean_on`: latency 1 cycle from `pix_x`/`pix_y`. Full throughput, one query per cycle.
- `beans_left` and `all_eaten` update on the same edge that clears `alive`.
- Asynchronous `reset` mid-SCAN forces all reset values immediately, independent of `clk`.

## Test plan
- Reset, then query `pix` = (10,10) → `bean_on` = 1 one cycle later. Query (9,10) → 0. Query (19,19) → 1. Query (20,19) → 0.
- Eat request (2,2) → `eat_ready` = 0 for 1 cycle, then `eaten_pulse` = 1 one cycle, `beans_left` = 9, and `bean_on` at (15,15) = 0 from the next query.
- Eat request (28,11), which is idx 9 → `eaten_pulse` on the 10th cycle after accept. Repeating (28,11) → no pulse, `eat_ready` low for 10 cycles, `beans_left` unchanged.
- Eat all 10 positions back to back with `eat_valid` held high → 10 pulses, `beans_left` = 0, `all_eaten` = 1. One further eat → `beans_left` stays 0.
- `restart` asserted on the 3rd SCAN cycle of request (39,2) → no pulse, state IDLE, `beans_left` = 10, `alive` all ones. A same-cycle `eat_valid` is ignored.
- Asynchronous `reset` pulse between clock edges during SCAN → all outputs take reset values before the next edge.
